// File: rtl/bch_enc_arbiter.sv
// Round-robin arbiter sharing one BCH(15,5) encoder among NUM_REQ requesters.
// Define BCH_ARB_FIXED_PRIO_EN for fixed priority (lowest request index wins).
module bch_enc_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [5*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [14:0]          rsp_codeword,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 enc_start,
  output logic [4:0]           enc_data,
  input  logic [14:0]          enc_codeword,
  input  logic                 enc_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [4:0]       msg_q, msg_d;
  logic [14:0]      cw_q, cw_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

`ifdef BCH_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req[i]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  int unsigned      rr_idx;

  // Search starts one past the last owner so the last winner has lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_idx   = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      rr_idx = (32'(ptr_q) + off) % NUM_REQ;
      if (!pick_vld && req[IDX_W'(rr_idx)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(rr_idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && pick_vld) ptr_d = pick_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IDX_W'(NUM_REQ - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    msg_d   = msg_q;
    cw_d    = cw_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          msg_d   = req_data[5*pick_idx +: 5];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_ARM;
      // enc_done may still be high from the previous job here, so it is not looked at.
      S_ARM: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (enc_done) begin
          cw_d    = enc_codeword;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cw_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      msg_q   <= '0;
      cw_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      msg_q   <= msg_d;
      cw_q    <= cw_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    if (state_q == S_LAUNCH) gnt[owner_q]       = 1'b1;
    if (state_q == S_RESP)   rsp_valid[owner_q] = 1'b1;
  end

  assign rsp_codeword = cw_q;
  assign rsp_err      = (state_q == S_RESP) && err_q;
  assign busy         = (state_q != S_IDLE);
  assign enc_start    = (state_q == S_LAUNCH);
  assign enc_data     = msg_q;

endmodule

// File: tb/tb_bch_enc_arbiter.sv
// Directed bench for bch_enc_arbiter with a behavioural encoder stub
// returning {message, 10'h2A5}; stub can hold done stale or never raise it.
module tb_bch_enc_arbiter;

  localparam int NR  = 4;
  localparam int TO  = 31;
  localparam int DLY = 6;  // done seen in cycle 7 when req is sampled in cycle 0

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [5*NR-1:0] req_data;
  logic [NR-1:0] gnt;
  logic [NR-1:0] rsp_valid;
  logic [14:0]   rsp_codeword;
  logic          rsp_err;
  logic          busy;
  logic          enc_start;
  logic [4:0]    enc_data;
  logic [14:0]   enc_codeword;
  logic          enc_done;

  int n_run  = 0;
  int n_fail = 0;

  bit   stale = 1'b0;
  bit   hang  = 1'b0;
  logic st_run;
  int   st_sc;
  logic st_done;

  always #5 clk = ~clk;

  bch_enc_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_codeword(rsp_codeword), .rsp_err(rsp_err),
    .busy(busy), .enc_start(enc_start), .enc_data(enc_data),
    .enc_codeword(enc_codeword), .enc_done(enc_done)
  );

  // Encoder stub: done clears one cycle after the start cycle, rises DLY cycles after start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_run  <= 1'b0;
      st_sc   <= 0;
      st_done <= 1'b0;
    end else begin
      if (enc_start) begin
        st_run <= 1'b1;
        st_sc  <= 1;
      end else if (st_run) begin
        st_sc <= st_sc + 1;
      end
      if (st_run && !hang && st_sc == DLY - 1) st_done <= 1'b1;
      else if (st_run && st_sc == 1)          st_done <= 1'b0;
      else if (st_run && !stale && st_sc == DLY) st_done <= 1'b0;
    end
  end

  assign enc_done     = st_done;
  assign enc_codeword = {enc_data, 10'h2A5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where req is sampled; returns in the RESP cycle.
  task automatic run_job(input int own, input int exp_lat, input logic exp_err,
                         input logic [4:0] msg, input bit drop);
    int lat;
    int extra;
    logic [14:0] exp_cw;
    lat   = 1;
    extra = 0;
    exp_cw = exp_err ? 15'h0 : {msg, 10'h2A5};
    tick();
    check("gnt", 32'(gnt), 32'(1 << own));
    check("enc_start", 32'(enc_start), 32'd1);
    check("enc_data", 32'(enc_data), 32'(msg));
    if (drop) req = '0;
    while (rsp_valid == '0 && lat < 60) begin
      tick();
      lat++;
      if (gnt != '0) extra++;
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_valid", 32'(rsp_valid), 32'(1 << own));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_codeword", 32'(rsp_codeword), 32'(exp_cw));
    check("extra_gnt", 32'(extra), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enc_start", 32'(enc_start), 32'd0);
    check("rst_enc_data", 32'(enc_data), 32'd0);
    check("rst_codeword", 32'(rsp_codeword), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single requester, codeword 15'h5AA5.
    req = 4'b0001;
    req_data = {15'h0, 5'b10110};
    check("idle_no_gnt", 32'(gnt), 32'd0);
    run_job(0, 8, 1'b0, 5'b10110, 1'b1);
    check("cw_5AA5", 32'(rsp_codeword), 32'h5AA5);
    tick();
    check("post_busy", 32'(busy), 32'd0);
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("cw_hold", 32'(rsp_codeword), 32'h5AA5);

    // All requesting from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data = {5'd4, 5'd3, 5'd2, 5'd1};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef BCH_ARB_FIXED_PRIO_EN
      run_job(0, 8, 1'b0, 5'd1, 1'b0);
`else
      run_job(k % 4, 8, 1'b0, 5'(k % 4 + 1), 1'b0);
`endif
      tick();
      check("rr_idle_busy", 32'(busy), 32'd0);
    end
    req = '0;
    tick();

`ifdef BCH_ARB_FIXED_PRIO_EN
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      run_job(1, 8, 1'b0, 5'd2, 1'b0);
      tick();
    end
    req = '0;
    tick();
`endif

    // Stale done from the previous job must not end the next one early.
    stale = 1'b1;
    req = 4'b0010;
    run_job(1, 8, 1'b0, 5'd2, 1'b1);
    tick();
    req = 4'b0010;
    run_job(1, 8, 1'b0, 5'd2, 1'b1);
    stale = 1'b0;
    tick();

    // Hung encoder: timeout, then normal service.
    hang = 1'b1;
    req = 4'b0100;
    run_job(2, TO + 3, 1'b1, 5'd3, 1'b1);
    tick();
    check("err_clears", 32'(rsp_err), 32'd0);
    check("cw_zero_hold", 32'(rsp_codeword), 32'd0);
    hang = 1'b0;
    req = 4'b1000;
    run_job(3, 8, 1'b0, 5'd4, 1'b1);
    tick();

    // Reset during WAIT.
    req = 4'b0010;
    tick();
    req = '0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_enc_start", 32'(enc_start), 32'd0);
    check("mid_rst_enc_data", 32'(enc_data), 32'd0);
    check("mid_rst_codeword", 32'(rsp_codeword), 32'd0);
    check("mid_rst_err", 32'(rsp_err), 32'd0);
    tick();
    rst = 1'b0;
    begin
      int rv;
      rv = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (rsp_valid != '0) rv++;
      end
      check("no_rsp_after_rst", 32'(rv), 32'd0);
    end
    req = 4'b0100;
    run_job(2, 8, 1'b0, 5'd3, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
